// File: rtl/uart_rx_cfg_if.sv
// uart_rx_cfg_if: serial line and decoded configuration word bundle.
interface uart_rx_cfg_if;
  logic        uart_rx;
  logic [19:0] rx_data;
  logic        rx_valid;
  logic        rx_err;
  logic        busy;
  modport master (input uart_rx, output rx_data, rx_valid, rx_err, busy);
  modport slave  (output uart_rx, input rx_data, rx_valid, rx_err, busy);
endinterface

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: 8N1 receiver that decodes sync-headed 4-byte frames into 20-bit config words.
module uart_rx_cfg #(
  parameter int         CLKS_PER_BIT = 434,
  parameter int         TIMEOUT_BITS = 20,
  parameter logic [7:0] SYNC_BYTE    = 8'h5A
) (
  input logic           clk,
  input logic           rst,
  uart_rx_cfg_if.master bus
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int TO = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TW = $clog2(TO + 1);
  localparam logic [CW-1:0] C_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] C_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] T_LAST = TW'(TO - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} eng_t;
  typedef enum logic [1:0] {WAIT_SYNC, B0, B1, B2} frm_t;
  eng_t          r_eng;
  frm_t          r_frm;
  logic          r_s1, r_s2, r_prev, r_armed;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit;
  logic [7:0]    r_sh;
  logic [15:0]   r_d;
  logic [TW-1:0] r_tcnt;
  logic [19:0]   r_data;
  logic          r_valid, r_err, r_busy;
  logic          w_fall, w_start, w_stop, w_ok, w_ferr, w_tout;
  assign w_fall  = r_prev & ~r_s2;
  assign w_start = r_eng == IDLE && r_armed && w_fall;
  // stop-bit decision is consumed by the frame FSM on the same edge it is sampled
  assign w_stop  = r_eng == STOP && r_cnt == C_LAST;
  assign w_ok    = w_stop & r_s2;
  assign w_ferr  = w_stop & ~r_s2;
  assign w_tout  = r_frm != WAIT_SYNC && r_eng == IDLE && r_tcnt == T_LAST;
  always_ff @(posedge clk) begin
    if (rst) begin
      {r_s1, r_s2, r_prev, r_armed} <= 4'hF;
      r_eng <= IDLE;
      r_cnt <= '0;
      r_bit <= '0;
      r_sh  <= '0;
    end else begin
      r_s1   <= bus.uart_rx;
      r_s2   <= r_s1;
      r_prev <= r_s2;
      case (r_eng)
        IDLE: begin
          if (r_s2) r_armed <= 1'b1;
          if (w_start) begin
            r_eng <= START;
            r_cnt <= '0;
          end
        end
        START: if (r_cnt == C_HALF) begin
          r_cnt <= '0;
          r_bit <= '0;
          r_eng <= r_s2 ? IDLE : DATA;
        end else r_cnt <= r_cnt + 1'b1;
        DATA: if (r_cnt == C_LAST) begin
          r_cnt <= '0;
          r_sh  <= {r_s2, r_sh[7:1]};
          r_bit <= r_bit + 1'b1;
          if (r_bit == 3'd7) r_eng <= STOP;
        end else r_cnt <= r_cnt + 1'b1;
        STOP: if (w_stop) begin
          r_cnt   <= '0;
          r_eng   <= IDLE;
          r_armed <= 1'b0;
        end else r_cnt <= r_cnt + 1'b1;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_frm   <= WAIT_SYNC;
      r_d     <= '0;
      r_tcnt  <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      if (w_tout) begin
        r_err  <= 1'b1;
        r_busy <= 1'b0;
        r_frm  <= WAIT_SYNC;
        r_tcnt <= '0;
      end else begin
        if (w_start) r_tcnt <= '0;
        else if (r_frm != WAIT_SYNC && r_eng == IDLE) r_tcnt <= r_tcnt + 1'b1;
        case (r_frm)
          WAIT_SYNC: if (w_ok && r_sh == SYNC_BYTE) begin
            r_frm  <= B0;
            r_busy <= 1'b1;
          end
          B0: if (w_ok) begin
            r_d[7:0] <= r_sh;
            r_frm    <= B1;
          end
          B1: if (w_ok) begin
            r_d[15:8] <= r_sh;
            r_frm     <= B2;
          end
          B2: if (w_ok) begin
            r_frm  <= WAIT_SYNC;
            r_busy <= 1'b0;
            if (r_sh[7:4] == 4'h0) begin
              r_data  <= {r_sh[3:0], r_d};
              r_valid <= 1'b1;
            end else r_err <= 1'b1;
          end
        endcase
        if (w_ferr && r_frm != WAIT_SYNC) begin
          r_err  <= 1'b1;
          r_busy <= 1'b0;
          r_frm  <= WAIT_SYNC;
        end
      end
    end
  end
  assign bus.rx_data  = r_data;
  assign bus.rx_valid = r_valid;
  assign bus.rx_err   = r_err;
  assign bus.busy     = r_busy;
endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: directed checks of uart_rx_cfg with 8 clocks per bit and a 4-bit timeout.
module tb_uart_rx_cfg;
  localparam int CPB = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int cyc = 0, total = 0, bad = 0;
  int n_valid = 0, n_err = 0, n_both = 0, v_cyc = 0, e_cyc = 0, last_start = 0;
  logic v_busy = 1'b1;
  logic [19:0] dlog [4];
  uart_rx_cfg_if bus ();
  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .TIMEOUT_BITS(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (bus.rx_valid) begin
      if (n_valid < 4) dlog[n_valid] = bus.rx_data;
      n_valid++;
      v_cyc = cyc;
      v_busy = bus.busy;
    end
    if (bus.rx_err) begin
      n_err++;
      e_cyc = cyc;
    end
    if (bus.rx_valid && bus.rx_err) n_both++;
  end
  task automatic drive_bit(input logic v);
    bus.uart_rx = v;
    repeat (CPB) @(posedge clk);
    #1;
  endtask
  task automatic idle(input int n);
    bus.uart_rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
    last_start = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop);
  endtask
  task automatic send_frame(input logic [19:0] d);
    send_byte(8'h5A);
    send_byte(d[7:0]);
    send_byte(d[15:8]);
    send_byte({4'h0, d[19:16]});
  endtask
  task automatic clr;
    n_valid = 0;
    n_err = 0;
  endtask
  task automatic test_reset;
    bus.uart_rx = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++; if (bus.rx_data !== 20'h0) begin bad++; $display("FAIL reset_data: got %h want 00000", bus.rx_data); end
    total++; if (bus.rx_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", bus.rx_valid); end
    total++; if (bus.rx_err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", bus.rx_err); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    rst = 1'b0;
    idle(4);
  endtask
  task automatic test_normal;
    clr();
    send_byte(8'h5A);
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL normal_busy_rise: got %b want 1", bus.busy); end
    send_byte(8'h03);
    send_byte(8'h00);
    send_byte(8'h00);
    idle(4);
    total++; if (n_valid !== 1) begin bad++; $display("FAIL normal_nvalid: got %0d want 1", n_valid); end
    total++; if (dlog[0] !== 20'h00003) begin bad++; $display("FAIL normal_data: got %h want 00003", dlog[0]); end
    total++; if (v_cyc !== last_start + 79) begin bad++; $display("FAIL normal_latency: got %0d want %0d", v_cyc, last_start + 79); end
    total++; if (v_busy !== 1'b0) begin bad++; $display("FAIL normal_busy_fall: got %b want 0", v_busy); end
    total++; if (n_err !== 0) begin bad++; $display("FAIL normal_err: got %0d want 0", n_err); end
    total++; if (bus.rx_data !== 20'h00003) begin bad++; $display("FAIL normal_hold: got %h want 00003", bus.rx_data); end
  endtask
  task automatic test_back_to_back;
    clr();
    send_frame(20'hABCDE);
    send_frame(20'h5A5A5);
    idle(4);
    total++; if (n_valid !== 2) begin bad++; $display("FAIL b2b_nvalid: got %0d want 2", n_valid); end
    total++; if (dlog[0] !== 20'hABCDE) begin bad++; $display("FAIL b2b_first: got %h want abcde", dlog[0]); end
    total++; if (dlog[1] !== 20'h5A5A5) begin bad++; $display("FAIL b2b_second: got %h want 5a5a5", dlog[1]); end
    total++; if (n_err !== 0) begin bad++; $display("FAIL b2b_err: got %0d want 0", n_err); end
  endtask
  task automatic test_header;
    clr();
    send_byte(8'h33);
    send_byte(8'h00);
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL header_busy: got %b want 0", bus.busy); end
    send_frame(20'h12345);
    idle(4);
    total++; if (n_valid !== 1) begin bad++; $display("FAIL header_nvalid: got %0d want 1", n_valid); end
    total++; if (dlog[0] !== 20'h12345) begin bad++; $display("FAIL header_data: got %h want 12345", dlog[0]); end
    total++; if (n_err !== 0) begin bad++; $display("FAIL header_err: got %0d want 0", n_err); end
  endtask
  task automatic test_glitch;
    clr();
    send_byte(8'h5A);
    bus.uart_rx = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    idle(12);
    send_byte(8'h77);
    send_byte(8'h07);
    send_byte(8'h00);
    idle(4);
    total++; if (n_valid !== 1) begin bad++; $display("FAIL glitch_nvalid: got %0d want 1", n_valid); end
    total++; if (dlog[0] !== 20'h00777) begin bad++; $display("FAIL glitch_data: got %h want 00777", dlog[0]); end
    total++; if (n_err !== 0) begin bad++; $display("FAIL glitch_err: got %0d want 0", n_err); end
  endtask
  task automatic test_ferr;
    clr();
    send_byte(8'h5A);
    send_byte(8'h11);
    send_byte(8'h22, 1'b0);
    idle(10);
    total++; if (n_err !== 1) begin bad++; $display("FAIL ferr_nerr: got %0d want 1", n_err); end
    total++; if (e_cyc !== last_start + 79) begin bad++; $display("FAIL ferr_cycle: got %0d want %0d", e_cyc, last_start + 79); end
    total++; if (n_valid !== 0) begin bad++; $display("FAIL ferr_nvalid: got %0d want 0", n_valid); end
    total++; if (bus.rx_data !== 20'h00777) begin bad++; $display("FAIL ferr_hold: got %h want 00777", bus.rx_data); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL ferr_busy: got %b want 0", bus.busy); end
    send_frame(20'h00001);
    idle(4);
    total++; if (n_valid !== 1 || dlog[0] !== 20'h00001) begin bad++; $display("FAIL ferr_recover: got %0d/%h want 1/00001", n_valid, dlog[0]); end
  endtask
  task automatic test_bad_nibble;
    clr();
    send_byte(8'h5A);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'hF3);
    idle(4);
    total++; if (n_err !== 1) begin bad++; $display("FAIL nibble_nerr: got %0d want 1", n_err); end
    total++; if (n_valid !== 0) begin bad++; $display("FAIL nibble_nvalid: got %0d want 0", n_valid); end
    total++; if (bus.rx_data !== 20'h00001) begin bad++; $display("FAIL nibble_hold: got %h want 00001", bus.rx_data); end
  endtask
  task automatic test_timeout;
    int t;
    clr();
    send_byte(8'h5A);
    send_byte(8'h11);
    t = last_start;
    idle(40);
    total++; if (n_err !== 1) begin bad++; $display("FAIL timeout_nerr: got %0d want 1", n_err); end
    total++; if (e_cyc !== t + 79 + 32) begin bad++; $display("FAIL timeout_cycle: got %0d want %0d", e_cyc, t + 111); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL timeout_busy: got %b want 0", bus.busy); end
    total++; if (n_valid !== 0) begin bad++; $display("FAIL timeout_nvalid: got %0d want 0", n_valid); end
  endtask
  task automatic test_rst_mid;
    clr();
    send_byte(8'h5A);
    send_byte(8'h11);
    bus.uart_rx = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    bus.uart_rx = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
    total++; if (bus.rx_data !== 20'h0) begin bad++; $display("FAIL rst_data: got %h want 00000", bus.rx_data); end
    total++; if (bus.rx_valid !== 1'b0 || bus.rx_err !== 1'b0) begin bad++; $display("FAIL rst_pulses: got %b%b want 00", bus.rx_valid, bus.rx_err); end
    rst = 1'b0;
    idle(60);
    total++; if (n_err !== 0) begin bad++; $display("FAIL rst_err: got %0d want 0", n_err); end
    send_frame(20'h00ABC);
    idle(4);
    total++; if (n_valid !== 1 || dlog[0] !== 20'h00ABC) begin bad++; $display("FAIL rst_recover: got %0d/%h want 1/00abc", n_valid, dlog[0]); end
  endtask
  initial begin
    test_reset();
    test_normal();
    test_back_to_back();
    test_header();
    test_glitch();
    test_ferr();
    test_bad_nibble();
    test_timeout();
    test_rst_mid();
    total++; if (n_both !== 0) begin bad++; $display("FAIL exclusive: got %0d want 0", n_both); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
